ps2_keycode: RTL

Receives PS/2 keyboard frames (scan code set 2) and produces the 8-bit HID-style `keycode` bus that the player car logic and game FSM consume. It is the producer end of the `keycode` interface: 0x04 A, 0x07 D, 0x16 S, 0x1A W, 0x15 R, 0x00 no key. It tracks make and break codes so that `keycode` holds a key's value for as long as that key is physically held. It sits between the board PS/2 pins and the game logic, replacing the USB/NIOS keycode path.

---
 rtl/ps2_keycode.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keycode.sv
// ps2_keycode: PS/2 keyboard (scan code set 2) receiver that turns make/break
// traffic into a HID-style keycode for the game logic.
//   Clk, Reset  : system clock, synchronous active-high reset
//   ps2_clk/data: raw PS/2 pins, asynchronous to Clk
//   keycode     : HID value of the most recently pressed still-held key, 0x00 if none
//   scan_code   : last good received byte
//   code_valid  : 1-cycle pulse when scan_code updates
//   frame_err   : 1-cycle pulse on start/parity/stop error or frame timeout
module ps2_keycode #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);
  localparam int             WDW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic [1:0]     clk_sync_q, dat_sync_q;
  logic           clk_prev_q;
  logic           fall, bit_in, timeout, good, bad;
  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           brk_q, brk_d, ext_q, ext_d;
  logic [4:0]     held_q, held_d;
  logic           last_vld_q, last_vld_d;
  logic [2:0]     last_q, last_d;
  logic [7:0]     scan_q, scan_d;
  logic           cv_q, cv_d, fe_q, fe_d;
  logic           key_hit;
  logic [2:0]     key_idx;

  assign fall    = clk_prev_q & ~clk_sync_q[1];
  assign bit_in  = dat_sync_q[1];
  // A fall in the terminal cycle wins: it proves the keyboard is still clocking.
  assign timeout = (state_q != IDLE) && !fall && (wd_q == WD_MAX);
  assign wd_d    = fall ? '0 : ((wd_q == WD_MAX) ? wd_q : wd_q + 1'b1);

  // Key index order doubles as fallback priority: W > S > A > D > R.
  always_comb begin
    key_hit = 1'b1;
    key_idx = 3'd0;
    case (shift_q)
      8'h1D:   key_idx = 3'd0;
      8'h1B:   key_idx = 3'd1;
      8'h1C:   key_idx = 3'd2;
      8'h23:   key_idx = 3'd3;
      8'h2D:   key_idx = 3'd4;
      default: key_hit = 1'b0;
    endcase
  end

  // Frame FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    good    = 1'b0;
    bad     = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      bad     = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d = DATA;
            cnt_d   = 3'd0;
          end else begin
            bad = 1'b1;
          end
        end
        DATA: begin
          shift_d = {bit_in, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = bit_in;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (bit_in && (^{shift_q, par_q})) good = 1'b1;
          else                               bad  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Byte decoder and held-key tracking
  always_comb begin
    brk_d      = brk_q;
    ext_d      = ext_q;
    held_d     = held_q;
    last_vld_d = last_vld_q;
    last_d     = last_q;
    scan_d     = scan_q;
    cv_d       = good;
    fe_d       = bad;
    if (bad) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (good) begin
      scan_d = shift_q;
      if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (key_hit && !ext_q) begin
          if (!brk_q) begin
            // Typematic repeats of a held key leave last untouched.
            if (!held_q[key_idx]) begin
              held_d[key_idx] = 1'b1;
              last_vld_d      = 1'b1;
              last_d          = key_idx;
            end
          end else if (held_q[key_idx]) begin
            held_d[key_idx] = 1'b0;
            if (last_vld_q && (last_q == key_idx)) begin
              // Descending scan so the lowest (highest-priority) index wins.
              last_vld_d = 1'b0;
              for (int i = 4; i >= 0; i--) begin
                if (held_d[i]) begin
                  last_vld_d = 1'b1;
                  last_d     = 3'(i);
                end
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // Sync chain resets to the idle-high level so no false fall follows reset.
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      wd_q       <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      held_q     <= 5'b0;
      last_vld_q <= 1'b0;
      last_q     <= 3'd0;
      scan_q     <= 8'h00;
      cv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      clk_prev_q <= clk_sync_q[1];
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      wd_q       <= wd_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      held_q     <= held_d;
      last_vld_q <= last_vld_d;
      last_q     <= last_d;
      scan_q     <= scan_d;
      cv_q       <= cv_d;
      fe_q       <= fe_d;
    end
  end

  always_comb begin
    keycode = 8'h00;
    if (last_vld_q) begin
      case (last_q)
        3'd0:    keycode = 8'h1A;
        3'd1:    keycode = 8'h16;
        3'd2:    keycode = 8'h04;
        3'd3:    keycode = 8'h07;
        3'd4:    keycode = 8'h15;
        default: keycode = 8'h00;
      endcase
    end
  end

  assign scan_code  = scan_q;
  assign code_valid = cv_q;
  assign frame_err  = fe_q;
endmodule
